// File: rtl/cmd_frame_parser.sv
// Command frame parser: assembles SYNC/CMD/ADDR/DATA/CHK frames from a UART byte
// stream and hands each valid command to the flash manager as a single trigger pulse.
module cmd_frame_parser #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 500000
) (
  input  logic       CLK_50MHZ,
  input  logic       RST_N,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       tx_trig,
  output logic       cmd_rx,
  output logic [7:0] addr_rx,
  output logic [7:0] data_rx,
  output logic       fl_trg,
  output logic       busy,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  // state     | meaning
  // HUNT      | discard bytes until SYNC_BYTE
  // GET_CMD   | waiting for command byte
  // GET_ADDR  | waiting for address byte
  // GET_DATA  | waiting for data byte
  // GET_CHK   | waiting for checksum byte, then validate
  // ISSUE     | publish command, pulse fl_trg
  // WAIT_DONE | hold outputs until tx_trig or timeout
  localparam logic [2:0] ST_HUNT      = 3'd0;
  localparam logic [2:0] ST_GET_CMD   = 3'd1;
  localparam logic [2:0] ST_GET_ADDR  = 3'd2;
  localparam logic [2:0] ST_GET_DATA  = 3'd3;
  localparam logic [2:0] ST_GET_CHK   = 3'd4;
  localparam logic [2:0] ST_ISSUE     = 3'd5;
  localparam logic [2:0] ST_WAIT_DONE = 3'd6;

  localparam int              TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          tx_trig_q, tx_trig_d;
  logic [7:0]    cmd_byte_q, cmd_byte_d;
  logic [7:0]    addr_byte_q, addr_byte_d;
  logic [7:0]    data_byte_q, data_byte_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          cmd_rx_q, cmd_rx_d;
  logic [7:0]    addr_rx_q, addr_rx_d;
  logic [7:0]    data_rx_q, data_rx_d;
  logic          fl_trg_q, fl_trg_d;
  logic          busy_q, busy_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic          tmo;
  logic          chk_pass;

  // UART inputs are registered once so the FSM only ever sees clean, aligned strobes
  assign rx_byte_d  = rx_byte;
  assign rx_valid_d = rx_valid;
  assign tx_trig_d  = tx_trig;

  assign tmo      = (tmr_q == TMO_LAST);
  assign chk_pass = (rx_byte_q == (cmd_byte_q ^ addr_byte_q ^ data_byte_q)) &&
                    (cmd_byte_q[7:1] == 7'd0);

  always_comb begin
    state_d     = state_q;
    cmd_byte_d  = cmd_byte_q;
    addr_byte_d = addr_byte_q;
    data_byte_d = data_byte_q;
    tmr_d       = tmr_q;
    cmd_rx_d    = cmd_rx_q;
    addr_rx_d   = addr_rx_q;
    data_rx_d   = data_rx_q;
    fl_trg_d    = 1'b0;
    busy_d      = busy_q;
    frame_err_d = 1'b0;

    case (state_q)
      ST_HUNT: begin
        tmr_d = '0;
        if (rx_valid_q && (rx_byte_q == SYNC_BYTE)) begin
          state_d = ST_GET_CMD;
        end
      end

      ST_GET_CMD, ST_GET_ADDR, ST_GET_DATA, ST_GET_CHK: begin
        if (rx_valid_q) begin
          tmr_d = '0;
          case (state_q)
            ST_GET_CMD: begin
              cmd_byte_d = rx_byte_q;
              state_d    = ST_GET_ADDR;
            end
            ST_GET_ADDR: begin
              addr_byte_d = rx_byte_q;
              state_d     = ST_GET_DATA;
            end
            ST_GET_DATA: begin
              data_byte_d = rx_byte_q;
              state_d     = ST_GET_CHK;
            end
            default: begin
              if (chk_pass) begin
                state_d = ST_ISSUE;
              end else begin
                state_d     = ST_HUNT;
                frame_err_d = 1'b1;
              end
            end
          endcase
        end else if (tmo) begin
          state_d     = ST_HUNT;
          frame_err_d = 1'b1;
          tmr_d       = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      ST_ISSUE: begin
        tmr_d       = '0;
        cmd_rx_d    = cmd_byte_q[0];
        addr_rx_d   = addr_byte_q;
        data_rx_d   = data_byte_q;
        fl_trg_d    = 1'b1;
        busy_d      = 1'b1;
        frame_err_d = rx_valid_q;
        state_d     = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        frame_err_d = rx_valid_q;
        if (tx_trig_q) begin
          state_d = ST_HUNT;
          busy_d  = 1'b0;
          tmr_d   = '0;
        end else if (tmo) begin
          state_d     = ST_HUNT;
          busy_d      = 1'b0;
          frame_err_d = 1'b1;
          tmr_d       = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      default: begin
        state_d = ST_HUNT;
        tmr_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // one count per error pulse, sticking at full scale
  assign err_cnt_d = (frame_err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

  always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_HUNT;
      rx_byte_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      tx_trig_q   <= 1'b0;
      cmd_byte_q  <= 8'd0;
      addr_byte_q <= 8'd0;
      data_byte_q <= 8'd0;
      tmr_q       <= '0;
      cmd_rx_q    <= 1'b0;
      addr_rx_q   <= 8'd0;
      data_rx_q   <= 8'd0;
      fl_trg_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      tx_trig_q   <= tx_trig_d;
      cmd_byte_q  <= cmd_byte_d;
      addr_byte_q <= addr_byte_d;
      data_byte_q <= data_byte_d;
      tmr_q       <= tmr_d;
      cmd_rx_q    <= cmd_rx_d;
      addr_rx_q   <= addr_rx_d;
      data_rx_q   <= data_rx_d;
      fl_trg_q    <= fl_trg_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_rx    = cmd_rx_q;
  assign addr_rx   = addr_rx_q;
  assign data_rx   = data_rx_q;
  assign fl_trg    = fl_trg_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Bench for cmd_frame_parser: directed frame scenarios plus random frames checked
// against a frame-level model (checksum/CMD rule, error tally, held outputs).
module tb_cmd_frame_parser;

  localparam int T = 40;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       tx_trig;
  logic       cmd_rx;
  logic [7:0] addr_rx;
  logic [7:0] data_rx;
  logic       fl_trg;
  logic       busy;
  logic       frame_err;
  logic [7:0] err_cnt;

  cmd_frame_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(T)) dut (
    .CLK_50MHZ (clk),
    .RST_N     (rst_n),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .tx_trig   (tx_trig),
    .cmd_rx    (cmd_rx),
    .addr_rx   (addr_rx),
    .data_rx   (data_rx),
    .fl_trg    (fl_trg),
    .busy      (busy),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec     = 0;
  int n_miscmp  = 0;
  int n_trg     = 0;
  int n_err     = 0;
  int exp_err   = 0;
  logic       exp_cmd  = 1'b0;
  logic [7:0] exp_addr = 8'd0;
  logic [7:0] exp_data = 8'd0;

  always @(negedge clk) begin
    if (fl_trg === 1'b1) n_trg++;
    if (frame_err === 1'b1) n_err++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit frame_ok(input logic [7:0] c, a, d, k);
    return (c[7:1] == 7'd0) && (k == (c ^ a ^ d));
  endfunction

  function automatic int sat_err(input int e);
    return (e > 255) ? 255 : e;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_noise(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h5A;
      send_byte(b);
    end
  endtask

  // full frame; returns with the parser in WAIT_DONE (good frame) or HUNT (rejected)
  task automatic do_frame(input logic [7:0] c, a, d, k);
    int t0, e0;
    bit ok;
    t0 = n_trg;
    e0 = n_err;
    ok = frame_ok(c, a, d, k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(a);
    send_byte(d);
    send_byte(k);
    @(negedge clk);
    check_eq("trg_early", fl_trg, 1'b0);
    @(negedge clk);
    if (ok) begin
      exp_cmd  = c[0];
      exp_addr = a;
      exp_data = d;
    end else begin
      exp_err++;
    end
    check_eq("trg_at_lat", fl_trg, ok);
    check_eq("busy_at_lat", busy, ok);
    check_eq("cmd_rx", cmd_rx, exp_cmd);
    check_eq("addr_rx", addr_rx, exp_addr);
    check_eq("data_rx", data_rx, exp_data);
    @(negedge clk);
    check_eq("trg_width", fl_trg, 1'b0);
    #1;
    check_eq("trg_count", n_trg - t0, ok);
    check_eq("err_pulses", n_err - e0, !ok);
    check_eq("err_cnt", err_cnt, sat_err(exp_err));
  endtask

  task automatic finish_txn(input int n_ovr);
    int e0;
    e0 = n_err;
    for (int i = 0; i < n_ovr; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      exp_err++;
    end
    check_eq("busy_hold", busy, 1'b1);
    @(negedge clk);
    tx_trig = 1'b1;
    @(negedge clk);
    tx_trig = 1'b0;
    @(negedge clk);
    check_eq("busy_clear", busy, 1'b0);
    check_eq("addr_stable", addr_rx, exp_addr);
    check_eq("data_stable", data_rx, exp_data);
    #1;
    check_eq("ovr_pulses", n_err - e0, n_ovr);
    check_eq("err_cnt_txn", err_cnt, sat_err(exp_err));
  endtask

  initial begin
    int e0, t0, cnt;
    logic [7:0] c, a, d, k;

    rst_n    = 1'b0;
    rx_byte  = 8'd0;
    rx_valid = 1'b0;
    tx_trig  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_trg", fl_trg, 1'b0);
    check_eq("rst_err_cnt", err_cnt, 8'd0);
    check_eq("rst_addr", addr_rx, 8'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write frame
    do_frame(8'h00, 8'h3C, 8'h5A, 8'h66);
    finish_txn(0);

    // read frame preceded by noise
    e0 = n_err;
    send_byte(8'h13);
    send_byte(8'h77);
    do_frame(8'h01, 8'h10, 8'h00, 8'h11);
    check_eq("noise_no_err", n_err - e0, 0);
    finish_txn(0);

    // bad checksum, then recovery
    do_frame(8'h00, 8'h3C, 8'h5A, 8'h67);
    do_frame(8'h00, 8'h3C, 8'h5A, 8'h66);
    finish_txn(0);

    // bad CMD high bits with consistent checksum
    do_frame(8'h02, 8'h11, 8'h22, 8'h02 ^ 8'h11 ^ 8'h22);

    // SYNC value as payload
    do_frame(8'h01, 8'hA5, 8'hA5, 8'h01);
    finish_txn(0);

    // inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h00);
    cnt = 0;
    while (frame_err !== 1'b1 && cnt < 3 * T) begin
      @(negedge clk);
      cnt++;
    end
    exp_err++;
    check_eq("tmo_seen", frame_err, 1'b1);
    check_eq("tmo_window", (cnt >= T - 1) && (cnt <= T + 3), 1'b1);
    repeat (2) @(negedge clk);
    do_frame(8'h00, 8'h3C, 8'h5A, 8'h66);
    finish_txn(0);

    // overrun during WAIT_DONE
    do_frame(8'h00, 8'h44, 8'h99, 8'h44 ^ 8'h99);
    finish_txn(3);

    // no completion: WAIT_DONE timeout
    do_frame(8'h01, 8'h21, 8'h43, 8'h01 ^ 8'h21 ^ 8'h43);
    e0 = n_err;
    cnt = 0;
    while (busy !== 1'b0 && cnt < 3 * T) begin
      @(negedge clk);
      cnt++;
    end
    exp_err++;
    check_eq("wd_tmo_busy", busy, 1'b0);
    check_eq("wd_tmo_window", (cnt >= T - 5) && (cnt <= T + 3), 1'b1);
    #1;
    check_eq("wd_tmo_err", n_err - e0, 1);
    check_eq("wd_tmo_cnt", err_cnt, sat_err(exp_err));

    // tx_trig and an overrun byte in the same cycle
    do_frame(8'h00, 8'h0F, 8'hF0, 8'hFF);
    e0 = n_err;
    @(negedge clk);
    tx_trig  = 1'b1;
    rx_valid = 1'b1;
    rx_byte  = 8'h33;
    @(negedge clk);
    tx_trig  = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    exp_err++;
    check_eq("sim_busy", busy, 1'b0);
    #1;
    check_eq("sim_err", n_err - e0, 1);

    // random frames against the frame-level model
    for (int i = 0; i < 150; i++) begin
      send_noise($urandom_range(0, 2));
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : {7'd0, 1'($urandom_range(0, 1))};
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      k = c ^ a ^ d;
      if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
      do_frame(c, a, d, k);
      if (frame_ok(c, a, d, k)) finish_txn($urandom_range(0, 2));
    end

    // reset mid-frame discards partial bytes
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h3C);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_err_cnt", err_cnt, 8'd0);
    check_eq("mid_rst_addr", addr_rx, 8'd0);
    check_eq("mid_rst_data", data_rx, 8'd0);
    check_eq("mid_rst_cmd", cmd_rx, 1'b0);
    exp_err  = 0;
    exp_cmd  = 1'b0;
    exp_addr = 8'd0;
    exp_data = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    t0 = n_trg;
    send_byte(8'h5A);
    send_byte(8'h66);
    repeat (4) @(negedge clk);
    #1;
    check_eq("post_rst_no_trg", n_trg - t0, 0);
    check_eq("post_rst_busy", busy, 1'b0);
    check_eq("post_rst_err_cnt", err_cnt, 8'd0);

    // error counter saturation
    for (int i = 0; i < 258; i++) begin
      do_frame(8'h00, 8'h12, 8'h34, 8'h00);
    end
    check_eq("sat_err_cnt", err_cnt, 8'hFF);
    do_frame(8'h01, 8'h55, 8'hAA, 8'h01 ^ 8'h55 ^ 8'hAA);
    finish_txn(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
